multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Moore-style control FSM for the multicycle LEGv8 datapath, replacing the single-cycle combinational main decoder. It sequences each instruction through fetch, decode, execute, memory and write-back states, and drives one set of datapath control signals per state. It handshakes with a variable-latency unified memory and enforces a parametrised memory timeout. It sits between the instruction register and the datapath/memory interface.

## Interface
- `OP_W`, 11: opcode field width taken from IR[31:21].
- `TIMEOUT`, 15: maximum cycles spent waiting for `mem_ready` in a memory state; 0 disables the timeout.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high.
- `Op` input OP_W: opcode from the instruction register; sampled only in DECODE.
- `mem_ready` input 1: memory has completed the current request this cycle.
- `mem_req` output 1: memory access request.
- `PCWrite`, `IRWrite` output 1: PC update (PC+4) and IR load.
- `Reg2Loc`, `ALUSrc`, `MemtoReg`, `RegWrite`, `MemRead`, `MemWrite`, `Branch` output 1: datapath controls, same meanings as in the single-cycle decoder.
- `ALUOp` output 2: 00 add, 01 pass/compare-zero, 10 R-type funct.
- `instr_done` output 1: one-cycle pulse in the final cycle of each instruction.
- `fault` output 1: high while the FSM is in FAULT.
- `state_o` output 4: current state encoding, for debug and coverage.

## Operation
- States and encodings: FETCH 0, DECODE 1, EX_R 2, EX_MOV 3, ALU_WB 4, MEM_ADDR 5, MEM_LD 6, LD_WB 7, MEM_ST 8, BR 9, FAULT 10. Encodings 11–15 are unreachable; if entered, go to FAULT.
- FETCH: `mem_req`=1, `MemRead`=1. Stay until `mem_ready`. On the ready cycle also assert `IRWrite`=1 and `PCWrite`=1, then go to DECODE.
- DECODE: latch `Op` into `op_q` and classify it. Transitions:
  - ADD/SUB/AND/ORR → EX_R.
  - LDUR/STUR → MEM_ADDR.
  - CBZ (10110100xxx) → BR.
  - MOVZ (110100101xx) → EX_MOV.
  - Illegal opcode: see Configuration.
- EX_R: `ALUSrc`=0, `ALUOp`=10 → ALU_WB.
- EX_MOV: `ALUSrc`=1, `ALUOp`=01 → ALU_WB.
- ALU_WB: `RegWrite`=1, `instr_done`=1 → FETCH.
- MEM_ADDR: `ALUSrc`=1, `ALUOp`=00 → MEM_LD if `op_q` is LDUR, otherwise MEM_ST.
- MEM_LD: `mem_req`=1, `MemRead`=1, `ALUSrc`=1. Wait for `mem_ready` → LD_WB.
- LD_WB: `MemtoReg`=1, `RegWrite`=1, `instr_done`=1 → FETCH.
- MEM_ST: `mem_req`=1, `MemWrite`=1, `Reg2Loc`=1, `ALUSrc`=1. On `mem_ready`, assert `instr_done`=1 → FETCH.
- BR: `Reg2Loc`=1, `ALUOp`=01, `Branch`=1, `instr_done`=1 → FETCH. The datapath gates the branch with its zero flag.
- FAULT: `fault`=1, all other outputs 0. The state is sticky; only `reset` leaves it.
- Wait counter (width $clog2(TIMEOUT+1)):
  - Cleared on entry to FETCH, MEM_LD and MEM_ST.
  - Increments each cycle spent in those states with `mem_ready`=0.
  - If the counter equals TIMEOUT and `mem_ready` is still 0, the next state is FAULT.
  - `mem_ready` arriving on the same cycle the limit is hit wins: normal progress, no fault.
- `mem_ready` is ignored in every non-memory state.
- Any control signal not listed for a state is 0 in that state.

## Timing
- All outputs are combinational decodes of the registered state (plus `mem_ready` in FETCH and MEM_ST). There is no output register.
- While `reset`=1, all outputs are 0, the next state is FETCH and the counter is cleared. Reset asserted mid-instruction aborts it with no further writes.
- Minimum latency with zero-wait memory:
  - R-type/MOVZ: 4 cycles.
  - LDUR: 5 cycles.
  - STUR: 4 cycles.
  - CBZ: 3 cycles.
- Each cycle of `mem_ready` delay adds one cycle.
- `instr_done` pulses exactly once per retired instruction and never in FAULT.

## Configuration
- `ILLEGAL_TRAP_EN` defined: an illegal opcode in DECODE → FAULT.
- `ILLEGAL_TRAP_EN` undefined: an illegal opcode is a NOP. DECODE asserts `instr_done`=1 and returns to FETCH, and no register or memory write occurs.

## Structure
- Package `legv8_ctrl_pkg`:
  - `state_t` enum with the encodings above.
  - Opcode `casez` constants.
  - ALUOp constants.
  - `op_class_t` enum: R, LD, ST, CBZ, MOVZ, ILLEGAL.
- Sub-module `op_classifier`: purely combinational, `Op` → `op_class_t`. It is used in DECODE and on `op_q`.

## Test plan
- ADD opcode 10001011000, `mem_ready` tied 1 → states 0,1,2,4. `RegWrite`=1 and `instr_done`=1 only in cycle 4; `ALUOp`=10 in EX_R.
- LDUR 11111000010 with `mem_ready` delayed 3 cycles in MEM_LD → 8-cycle instruction. `MemtoReg`=`RegWrite`=1 for exactly one cycle in LD_WB.
- STUR 11111000000 then CBZ 10110100101 back-to-back, zero-wait → 4+3 cycles. `MemWrite` is asserted only in MEM_ST, `Branch` only in BR, and `RegWrite` is never asserted.
- TIMEOUT=15, `mem_ready` held 0 in FETCH → FAULT entered after 16 FETCH cycles with `fault`=1. A `reset` pulse returns the FSM to FETCH.
- Opcode 00000000000: with `ILLEGAL_TRAP_EN` → FAULT after DECODE. Without it → `instr_done` in DECODE, then FETCH, with no writes.
- `reset` asserted during MEM_LD wait → next cycle `state_o`=0, and `mem_req` and `MemRead` are 0 while reset is high.

Source files
------------

// File: rtl/legv8_ctrl_pkg.sv
// rtl/legv8_ctrl_pkg.sv - shared types and constants for the multicycle LEGv8 control FSM
// Contents: state_t (FSM encodings), opcode casez patterns, ALUOp codes, op_class_t.
package legv8_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EX_R     = 4'd2,
        S_EX_MOV   = 4'd3,
        S_ALU_WB   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_LD   = 4'd6,
        S_LD_WB    = 4'd7,
        S_MEM_ST   = 4'd8,
        S_BR       = 4'd9,
        S_FAULT    = 4'd10
    } state_t;

    // Opcode patterns for IR[31:21]; '?' bits are don't-care under casez.
    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [10:0] OPC_CBZ  = 11'b10110100???;
    localparam logic [10:0] OPC_MOVZ = 11'b110100101??;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_PASS  = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_LD,
        CLS_ST,
        CLS_CBZ,
        CLS_MOVZ,
        CLS_ILLEGAL
    } op_class_t;

endpackage

// File: rtl/op_classifier.sv
// rtl/op_classifier.sv - combinational opcode to instruction-class decode
// Ports: i_op (opcode field) -> o_cls (op_class_t).
module op_classifier
    import legv8_ctrl_pkg::*;
#(
    parameter int OP_W = 11
) (
    input  logic [OP_W-1:0] i_op,
    output op_class_t       o_cls
);

    always_comb begin
        o_cls = CLS_ILLEGAL;
        casez (i_op)
            OPC_ADD, OPC_SUB, OPC_AND, OPC_ORR: o_cls = CLS_R;
            OPC_LDUR:                           o_cls = CLS_LD;
            OPC_STUR:                           o_cls = CLS_ST;
            OPC_CBZ:                            o_cls = CLS_CBZ;
            OPC_MOVZ:                           o_cls = CLS_MOVZ;
            default:                            o_cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - Moore control FSM for the multicycle LEGv8 datapath
// Ports: clk, reset (sync, active-high), Op (IR opcode), mem_ready (memory handshake);
//        mem_req, PCWrite, IRWrite, Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead,
//        MemWrite, Branch, ALUOp[1:0], instr_done, fault, state_o[3:0].
// Macro: ILLEGAL_TRAP_EN - illegal opcode in DECODE traps to FAULT instead of a NOP.
module multicycle_ctrl
    import legv8_ctrl_pkg::*;
#(
    parameter int OP_W    = 11,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] Op,
    input  logic            mem_ready,
    output logic            mem_req,
    output logic            PCWrite,
    output logic            IRWrite,
    output logic            Reg2Loc,
    output logic            ALUSrc,
    output logic            MemtoReg,
    output logic            RegWrite,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            Branch,
    output logic [1:0]      ALUOp,
    output logic            instr_done,
    output logic            fault,
    output logic [3:0]      state_o
);

    // Keep the counter at least one bit wide when the timeout is disabled.
    localparam int              CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [OP_W-1:0]   r_op_q;
    op_class_t         w_cls_dec;
    op_class_t         w_cls_q;
    logic              w_wait_state;
    logic              w_timeout;

    op_classifier #(.OP_W(OP_W)) u_cls_dec (.i_op(Op),     .o_cls(w_cls_dec));
    op_classifier #(.OP_W(OP_W)) u_cls_q   (.i_op(r_op_q), .o_cls(w_cls_q));

    assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEM_LD) || (r_state == S_MEM_ST);
    // A ready on the limit cycle is not a timeout: mem_ready gates the fault.
    assign w_timeout    = (TIMEOUT != 0) && w_wait_state && !mem_ready && (r_cnt == CNT_MAX);
    assign state_o      = reset ? 4'd0 : r_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
            r_op_q  <= '0;
        end else begin
            r_state <= w_next;
            // Any state change clears the counter, so every entry into a wait state starts at 0.
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (w_wait_state && !mem_ready) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == S_DECODE) begin
                r_op_q <= Op;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        mem_req    = 1'b0;
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        Reg2Loc    = 1'b0;
        ALUSrc     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        Branch     = 1'b0;
        ALUOp      = ALUOP_ADD;
        instr_done = 1'b0;
        fault      = 1'b0;

        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    w_next  = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_FAULT;
                end
            end
            S_DECODE: begin
                case (w_cls_dec)
                    CLS_R:          w_next = S_EX_R;
                    CLS_LD, CLS_ST: w_next = S_MEM_ADDR;
                    CLS_CBZ:        w_next = S_BR;
                    CLS_MOVZ:       w_next = S_EX_MOV;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        w_next = S_FAULT;
`else
                        instr_done = 1'b1;
                        w_next     = S_FETCH;
`endif
                    end
                endcase
            end
            S_EX_R: begin
                ALUOp  = ALUOP_RTYPE;
                w_next = S_ALU_WB;
            end
            S_EX_MOV: begin
                ALUSrc = 1'b1;
                ALUOp  = ALUOP_PASS;
                w_next = S_ALU_WB;
            end
            S_ALU_WB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEM_ADDR: begin
                ALUSrc = 1'b1;
                w_next = (w_cls_q == CLS_LD) ? S_MEM_LD : S_MEM_ST;
            end
            S_MEM_LD: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
                ALUSrc  = 1'b1;
                if (mem_ready)      w_next = S_LD_WB;
                else if (w_timeout) w_next = S_FAULT;
            end
            S_LD_WB: begin
                MemtoReg   = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEM_ST: begin
                mem_req  = 1'b1;
                MemWrite = 1'b1;
                Reg2Loc  = 1'b1;
                ALUSrc   = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    w_next     = S_FETCH;
                end else if (w_timeout) begin
                    w_next = S_FAULT;
                end
            end
            S_BR: begin
                Reg2Loc    = 1'b1;
                ALUOp      = ALUOP_PASS;
                Branch     = 1'b1;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_FAULT: begin
                fault  = 1'b1;
                w_next = S_FAULT;
            end
            default: w_next = S_FAULT;
        endcase

        // Reset forces every output low, even while the old state is still registered.
        if (reset) begin
            mem_req    = 1'b0;
            PCWrite    = 1'b0;
            IRWrite    = 1'b0;
            Reg2Loc    = 1'b0;
            ALUSrc     = 1'b0;
            MemtoReg   = 1'b0;
            RegWrite   = 1'b0;
            MemRead    = 1'b0;
            MemWrite   = 1'b0;
            Branch     = 1'b0;
            ALUOp      = ALUOP_ADD;
            instr_done = 1'b0;
            fault      = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard testbench for multicycle_ctrl
module tb_multicycle_ctrl;

    localparam logic [3:0] F = 4'd0, D = 4'd1, XR = 4'd2, XM = 4'd3, AW = 4'd4,
                           MA = 4'd5, ML = 4'd6, LW = 4'd7, MS = 4'd8, BR = 4'd9, FLT = 4'd10;

    localparam logic [10:0] ADD  = 11'b10001011000;
    localparam logic [10:0] SUB  = 11'b11001011000;
    localparam logic [10:0] AND_ = 11'b10001010000;
    localparam logic [10:0] ORR  = 11'b10101010000;
    localparam logic [10:0] LDUR = 11'b11111000010;
    localparam logic [10:0] STUR = 11'b11111000000;
    localparam logic [10:0] CBZ  = 11'b10110100101;
    localparam logic [10:0] MOVZ = 11'b11010010110;
    localparam logic [10:0] ILL  = 11'b00000000000;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] Op;
    logic        mem_ready;
    logic        mem_req, PCWrite, IRWrite, Reg2Loc, ALUSrc, MemtoReg, RegWrite;
    logic        MemRead, MemWrite, Branch, instr_done, fault;
    logic [1:0]  ALUOp;
    logic [3:0]  state_o;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_done  = 0;
    int          n_exp_done = 0;
    int          step_no = 0;
    logic [10:0] cur_op = '0;
    string       q_tag[$];
    logic [17:0] q_exp[$];
    logic [17:0] w_got;

    always #5 clk = ~clk;

    multicycle_ctrl #(.OP_W(11), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .Op(Op), .mem_ready(mem_ready),
        .mem_req(mem_req), .PCWrite(PCWrite), .IRWrite(IRWrite), .Reg2Loc(Reg2Loc),
        .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemRead(MemRead),
        .MemWrite(MemWrite), .Branch(Branch), .ALUOp(ALUOp), .instr_done(instr_done),
        .fault(fault), .state_o(state_o)
    );

    assign w_got = {state_o, mem_req, PCWrite, IRWrite, Reg2Loc, ALUSrc, MemtoReg,
                    RegWrite, MemRead, MemWrite, Branch, ALUOp, instr_done, fault};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected outputs for one cycle, straight from the per-state control table.
    function automatic logic [17:0] exp_vec(input logic [3:0] st, input logic rdy,
                                            input logic rst, input logic nop);
        logic mreq, pcw, irw, r2l, asrc, m2r, rw, mr, mw, br, idn, flt;
        logic [1:0] aop;
        {mreq, pcw, irw, r2l, asrc, m2r, rw, mr, mw, br, idn, flt} = '0;
        aop = 2'b00;
        if (!rst) begin
            case (st)
                F:   begin mreq = 1; mr = 1; pcw = rdy; irw = rdy; end
                D:   idn = nop;
                XR:  aop = 2'b10;
                XM:  begin asrc = 1; aop = 2'b01; end
                AW:  begin rw = 1; idn = 1; end
                MA:  asrc = 1;
                ML:  begin mreq = 1; mr = 1; asrc = 1; end
                LW:  begin m2r = 1; rw = 1; idn = 1; end
                MS:  begin mreq = 1; mw = 1; r2l = 1; asrc = 1; idn = rdy; end
                BR:  begin r2l = 1; aop = 2'b01; br = 1; idn = 1; end
                FLT: flt = 1;
                default: ;
            endcase
        end
        return {rst ? 4'd0 : st, mreq, pcw, irw, r2l, asrc, m2r, rw, mr, mw, br, aop, idn, flt};
    endfunction

    // Drive one cycle and queue what the DUT must show during it.
    task automatic cyc(input string name, input logic rst, input logic [3:0] st,
                       input logic rdy, input logic nop = 1'b0);
        logic [17:0] e;
        reset     = rst;
        mem_ready = rdy;
        Op        = (st == D && !rst) ? cur_op : 11'($urandom);
        e         = exp_vec(st, rdy, rst, nop);
        if (e[1]) n_exp_done++;
        q_tag.push_back($sformatf("%s_%0d", name, step_no));
        q_exp.push_back(e);
        step_no++;
        @(posedge clk);
        #1;
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic run_alu(input string name, input logic [10:0] op, input logic [3:0] ex);
        cur_op = op;
        cyc(name, 0, F, 1);
        cyc(name, 0, D, rnd());
        cyc(name, 0, ex, rnd());
        cyc(name, 0, AW, rnd());
    endtask

    always @(negedge clk) begin
        if (instr_done === 1'b1) n_done++;
        if (q_exp.size() != 0) begin
            check(q_tag.pop_front(), 32'(w_got), 32'(q_exp.pop_front()));
        end
    end

    initial begin
        reset = 1'b1; mem_ready = 1'b0; Op = '0;
        repeat (2) @(posedge clk);
        #1;
        cyc("rst", 1, F, 0);
        cyc("rst", 1, F, 1);

        run_alu("add", ADD, XR);

        cur_op = LDUR;
        cyc("ldur", 0, F, 1); cyc("ldur", 0, D, rnd()); cyc("ldur", 0, MA, rnd());
        repeat (3) cyc("ldur", 0, ML, 0);
        cyc("ldur", 0, ML, 1); cyc("ldur", 0, LW, rnd());

        cur_op = STUR;
        cyc("stur", 0, F, 1); cyc("stur", 0, D, rnd()); cyc("stur", 0, MA, rnd()); cyc("stur", 0, MS, 1);
        cur_op = CBZ;
        cyc("cbz", 0, F, 1); cyc("cbz", 0, D, rnd()); cyc("cbz", 0, BR, rnd());

        run_alu("movz", MOVZ, XM);
        run_alu("sub", SUB, XR);
        run_alu("and", AND_, XR);
        run_alu("orr", ORR, XR);

        cur_op = ADD;
        cyc("fwait", 0, F, 0); cyc("fwait", 0, F, 0);
        cyc("fwait", 0, F, 1); cyc("fwait", 0, D, rnd()); cyc("fwait", 0, XR, rnd()); cyc("fwait", 0, AW, rnd());

        // Ready arrives exactly on the limit cycle: must complete, not fault.
        cur_op = STUR;
        cyc("stlim", 0, F, 1); cyc("stlim", 0, D, rnd()); cyc("stlim", 0, MA, rnd());
        repeat (15) cyc("stlim", 0, MS, 0);
        cyc("stlim", 0, MS, 1);

        cur_op = ILL;
        cyc("ill", 0, F, 1);
`ifdef ILLEGAL_TRAP_EN
        cyc("ill", 0, D, rnd(), 0);
        cyc("ill", 0, FLT, rnd()); cyc("ill", 0, FLT, rnd());
        cyc("ill", 1, F, rnd());
`else
        cyc("ill", 0, D, rnd(), 1);
`endif
        run_alu("post_ill", ADD, XR);

        cur_op = LDUR;
        cyc("ldrst", 0, F, 1); cyc("ldrst", 0, D, rnd()); cyc("ldrst", 0, MA, rnd());
        cyc("ldrst", 0, ML, 0); cyc("ldrst", 0, ML, 0);
        cyc("ldrst", 1, F, 0);
        run_alu("post_ldrst", ADD, XR);

        cur_op = ADD;
        repeat (16) cyc("tmo", 0, F, 0);
        repeat (3) cyc("tmo", 0, FLT, rnd());
        cyc("tmo", 1, F, 0);
        run_alu("post_tmo", ORR, XR);

        @(negedge clk);
        #1;
        check("done_count", 32'(n_done), 32'(n_exp_done));
        check("sb_empty", 32'(q_exp.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
